// File: rtl/tono_pkg.sv
// Shared constants and types for the buzzer tone generator.
package tono_pkg;

  localparam int WIDTH_DEF      = 52;
  localparam int MIN_PERIOD_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } estado_t;

  typedef logic [WIDTH_DEF-1:0] periodo_t;

endpackage

// File: rtl/contador_periodo.sv
// Half-period cycle counter: counts up from 0, flags the last cycle of the half period.
module contador_periodo
  import tono_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] periodo,
  output logic [WIDTH-1:0] cnt,
  output logic             fin
);

  localparam logic [WIDTH-1:0] UNO = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + UNO;
  end

  assign fin = (cnt == (periodo - UNO));

endmodule

// File: rtl/generador_tono.sv
// Glitch-free square-wave generator for the board buzzer; changes apply only on half-period boundaries.
// Optional full-period counter output `ciclos` enabled by defining CONTADOR_CICLOS_EN.
module generador_tono
  import tono_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sonido,
  output logic             altavoz,
  output logic             activo,
`ifdef CONTADOR_CICLOS_EN
  output logic [15:0]      ciclos,
`endif
  output logic             recarga
);

  localparam logic [WIDTH-1:0] MINP = WIDTH'(MIN_PERIOD);

  estado_t          estado, estado_d;
  logic [WIDTH-1:0] periodo, periodo_d;
  logic [WIDTH-1:0] cnt;
  logic             altavoz_d, recarga_d;
  logic             req, fin, clr;

  assign req = enable && (sonido >= MINP);
  // Counter is held at 0 in IDLE and restarts at every boundary.
  assign clr = (estado == IDLE) || fin;

  contador_periodo #(.WIDTH(WIDTH)) u_contador (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .periodo (periodo),
    .cnt     (cnt),
    .fin     (fin)
  );

  always_comb begin
    estado_d  = estado;
    periodo_d = periodo;
    altavoz_d = altavoz;
    recarga_d = 1'b0;
    case (estado)
      IDLE: begin
        altavoz_d = 1'b0;
        if (req) begin
          estado_d  = RUN;
          periodo_d = sonido;
          altavoz_d = 1'b1;
          recarga_d = 1'b1;
        end
      end
      RUN: begin
        if (fin) begin
          if (req) begin
            altavoz_d = ~altavoz;
            periodo_d = sonido;
            recarga_d = 1'b1;
          end else begin
            altavoz_d = 1'b0;
            estado_d  = IDLE;
          end
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado  <= IDLE;
      periodo <= '0;
      altavoz <= 1'b0;
      recarga <= 1'b0;
    end else begin
      estado  <= estado_d;
      periodo <= periodo_d;
      altavoz <= altavoz_d;
      recarga <= recarga_d;
    end
  end

  assign activo = (estado == RUN);

`ifdef CONTADOR_CICLOS_EN
  // A falling edge happens on any boundary taken while the output is high.
  logic cae;
  assign cae = (estado == RUN) && fin && altavoz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ciclos <= '0;
    else if (estado == IDLE && req)     ciclos <= '0;
    else if (cae && ciclos != 16'hFFFF) ciclos <= ciclos + 16'd1;
  end
`endif

endmodule

// File: tb/tb_generador_tono.sv
// Bench for generador_tono: directed scenarios plus random traffic against a half-period model.
module tb_generador_tono;

  localparam int W    = 52;
  localparam int MINP = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] sonido;
  logic         altavoz, activo, recarga;
`ifdef CONTADOR_CICLOS_EN
  logic [15:0]  ciclos;
`endif

  int checks = 0;
  int errors = 0;

  // Model: running flag, output level, edges left in the current half period.
  bit              m_run, m_alt, m_rec;
  longint unsigned m_left;
  int              m_cic;

  always #5 clk = ~clk;

  generador_tono #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .sonido  (sonido),
    .altavoz (altavoz),
    .activo  (activo),
`ifdef CONTADOR_CICLOS_EN
    .ciclos  (ciclos),
`endif
    .recarga (recarga)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_alt = 0; m_rec = 0; m_left = 0; m_cic = 0;
  endfunction

  function automatic void model_edge(input bit en, input longint unsigned s);
    bit req;
    req   = en && (s >= MINP);
    m_rec = 0;
    if (!m_run) begin
      if (req) begin
        m_run = 1; m_alt = 1; m_left = s; m_rec = 1; m_cic = 0;
      end
    end else if (m_left > 1) begin
      m_left--;
    end else if (req) begin
      if (m_alt && m_cic < 65535) m_cic++;
      m_alt  = !m_alt;
      m_left = s;
      m_rec  = 1;
    end else begin
      if (m_alt && m_cic < 65535) m_cic++;
      m_alt = 0;
      m_run = 0;
    end
  endfunction

  task automatic compare();
    chk("altavoz", 64'(altavoz), 64'(m_alt));
    chk("activo",  64'(activo),  64'(m_run));
    chk("recarga", 64'(recarga), 64'(m_rec));
`ifdef CONTADOR_CICLOS_EN
    chk("ciclos",  64'(ciclos),  64'(m_cic));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(enable, 64'(sonido));
    #1;
    compare();
  endtask

  // Counts consecutive cycles at level lvl, starting from an already-seen count.
  task automatic medir(input logic lvl, input int start, output int n);
    n = start;
    for (int i = 0; i < 40 && altavoz === lvl; i++) begin
      step();
      if (altavoz === lvl) n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; sonido = '0;
    model_reset();
    #2 reset = 1'b0;
    #10;
    chk("rst_altavoz", 64'(altavoz), 64'd0);
    chk("rst_activo",  64'(activo),  64'd0);
    chk("rst_recarga", 64'(recarga), 64'd0);
    chk("rst_cnt",     64'(dut.u_contador.cnt), 64'd0);
    @(negedge clk) reset = 1'b1;
    step();

    // Steady tone at 4
    enable = 1'b1; sonido = W'(4);
    step();
    chk("arranque_altavoz", 64'(altavoz), 64'd1);
    chk("arranque_recarga", 64'(recarga), 64'd1);
    medir(1'b1, 1, n); chk("alto_4", 64'(n), 64'd4);
    medir(1'b0, 1, n); chk("bajo_4", 64'(n), 64'd4);

    // Change to 6 mid half period
    sonido = W'(6);
    medir(1'b1, 1, n); chk("alto_antes_6", 64'(n), 64'd4);
    medir(1'b0, 1, n); chk("bajo_6", 64'(n), 64'd6);

    // Stop two cycles into a high phase at 5
    sonido = W'(5);
    medir(1'b1, 1, n); chk("alto_6", 64'(n), 64'd6);
    medir(1'b0, 1, n); chk("bajo_5", 64'(n), 64'd5);
    step();
    enable = 1'b0;
    medir(1'b1, 2, n); chk("alto_parada_5", 64'(n), 64'd5);
    chk("parada_activo", 64'(activo), 64'd0);
    repeat (4) step();

    // One-cycle enable glitch mid phase
    enable = 1'b1; sonido = W'(4);
    step();
    step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    chk("glitch_activo", 64'(activo), 64'd1);
    medir(1'b1, 3, n); chk("glitch_alto", 64'(n), 64'd4);
    medir(1'b0, 1, n); chk("glitch_bajo", 64'(n), 64'd4);
    enable = 1'b0;
    repeat (10) step();

    // Sub-minimum half periods are silence
    enable = 1'b1; sonido = W'(1);
    repeat (5) step();
    chk("son1_activo", 64'(activo), 64'd0);
    sonido = W'(0);
    repeat (5) step();
    chk("son0_activo", 64'(activo), 64'd0);
    chk("son0_altavoz", 64'(altavoz), 64'd0);

    // Asynchronous reset mid high phase
    sonido = W'(3);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("rst_async_altavoz", 64'(altavoz), 64'd0);
    chk("rst_async_activo",  64'(activo),  64'd0);
    chk("rst_async_cnt",     64'(dut.u_contador.cnt), 64'd0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    step();
    chk("rearranque_altavoz", 64'(altavoz), 64'd1);
    medir(1'b1, 1, n); chk("r_alto1", 64'(n), 64'd3);
    medir(1'b0, 1, n); chk("r_bajo1", 64'(n), 64'd3);
    medir(1'b1, 1, n); chk("r_alto2", 64'(n), 64'd3);
    medir(1'b0, 1, n); chk("r_bajo2", 64'(n), 64'd3);
    medir(1'b1, 1, n); chk("r_alto3", 64'(n), 64'd3);
    enable = 1'b0;
    repeat (3) step();
    chk("r_parada_activo", 64'(activo), 64'd0);
`ifdef CONTADOR_CICLOS_EN
    chk("ciclos_3", 64'(ciclos), 64'd3);
`endif

    // Largest half period latches and counts without trouble
    enable = 1'b1; sonido = '1;
    step();
    chk("max_recarga", 64'(recarga), 64'd1);
    repeat (3) step();
    chk("max_cnt", 64'(dut.u_contador.cnt), 64'd3);
    enable = 1'b0;
    @(negedge clk) reset = 1'b0;
    model_reset();
    #1 chk("max_rst_activo", 64'(activo), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      if ($urandom_range(0, 5) == 0) sonido = W'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
